// File: rtl/sysa_pkg.sv
// ============================================================================
// Module      : sysa_pkg
// Description : Shared defaults, state encoding and row-slice helpers for the
//               systolic-array job sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sysa_pkg;

    localparam int c_N_DEF   = 3;
    localparam int c_DW_DEF  = 8;
    localparam int c_OW_DEF  = 16;
    localparam int c_LAT_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_STREAM = 3'd3,
        ST_UNLOAD = 3'd4
    } state_t;

    // LSB of row `row` in a flat buffer of rows that are `row_w` bits wide.
    function automatic int row_lsb(input int row, input int row_w);
        return row * row_w;
    endfunction

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sysa_skew.sv
// ============================================================================
// Module      : sysa_skew
// Description : Combinational skew of the activation buffer onto the array
//               input lanes, and per-lane capture strobes for the de-skewed
//               output wavefront.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysa_skew
    import sysa_pkg::*;
#(
    parameter int N   = c_N_DEF,
    parameter int DW  = c_DW_DEF,
    parameter int LAT = c_LAT_DEF,
    parameter int TW  = 3,
    parameter int RW  = 2
) (
    input  logic [N*N*DW-1:0] i_abuf,
    input  logic [TW-1:0]     i_t,
    output logic [N*DW-1:0]   o_sa_in,
    output logic [N-1:0]      o_cap_en,
    output logic [N*RW-1:0]   o_cap_row
);

    // Lane k carries a[t-k][k]; zero outside the diagonal band.
    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [DW-1:0] w_lane;
        always_comb begin
            w_lane = '0;
            for (int r = 0; r < N; r++) begin
                if (i_t == TW'(r + k)) begin
                    w_lane = i_abuf[(r*N + k)*DW +: DW];
                end
            end
        end
        assign o_sa_in[k*DW +: DW] = w_lane;
    end

    // Output lane j holds row r at t = r + j + LAT.
    for (genvar j = 0; j < N; j++) begin : g_cap
        logic          w_en;
        logic [RW-1:0] w_row;
        always_comb begin
            w_en  = 1'b0;
            w_row = '0;
            for (int r = 0; r < N; r++) begin
                if (i_t == TW'(r + j + LAT)) begin
                    w_en  = 1'b1;
                    w_row = RW'(r);
                end
            end
        end
        assign o_cap_en[j]             = w_en;
        assign o_cap_row[j*RW +: RW]   = w_row;
    end

endmodule

`default_nettype wire

// File: rtl/sysa_sequencer.sv
// ============================================================================
// Module      : sysa_sequencer
// Description : Job controller for the NxN weight-stationary systolic array:
//               weight load, activation load, skewed stream, result unload.
//               Optional macro SEQ_PERF_EN adds the perf_cycles counter port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysa_sequencer
    import sysa_pkg::*;
#(
    parameter int N   = c_N_DEF,
    parameter int DW  = c_DW_DEF,
    parameter int OW  = c_OW_DEF,
    parameter int LAT = c_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              keep_w,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [N*DW-1:0]   w_data,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [N*DW-1:0]   a_data,
    output logic              sa_en,
    output logic [N*N*DW-1:0] sa_wgt,
    output logic [N*DW-1:0]   sa_in,
    input  logic [N*OW-1:0]   sa_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N*OW-1:0]   res_data,
    output logic              busy,
    output logic              done
`ifdef SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int c_T_LAST = 2*N - 2 + LAT;
    localparam int c_TW     = idx_w(c_T_LAST + 1);
    localparam int c_RW     = idx_w(N);

    state_t              r_state;
    state_t              w_next;
    logic [N*N*DW-1:0]   r_wbuf;
    logic [N*N*DW-1:0]   r_abuf;
    logic [N*N*OW-1:0]   r_res;
    logic [c_RW-1:0]     r_k;
    logic [c_RW-1:0]     r_u;
    logic [c_TW-1:0]     r_t;
    logic                r_w_loaded;
    logic                r_done;

    logic [N*DW-1:0]     w_skew_in;
    logic [N-1:0]        w_cap_en;
    logic [N*c_RW-1:0]   w_cap_row;
    logic [N*OW-1:0]     w_res_row;
    logic                w_start_ok;
    logic                w_w_fire;
    logic                w_a_fire;
    logic                w_r_fire;
    logic                w_k_last;
    logic                w_u_last;
    logic                w_t_last;

    sysa_skew #(
        .N   (N),
        .DW  (DW),
        .LAT (LAT),
        .TW  (c_TW),
        .RW  (c_RW)
    ) u_skew (
        .i_abuf    (r_abuf),
        .i_t       (r_t),
        .o_sa_in   (w_skew_in),
        .o_cap_en  (w_cap_en),
        .o_cap_row (w_cap_row)
    );

    // A start coinciding with the done pulse is left for the following cycle.
    assign w_start_ok = (r_state == ST_IDLE) && start && !r_done;
    assign w_w_fire   = w_valid && w_ready;
    assign w_a_fire   = a_valid && a_ready;
    assign w_r_fire   = res_valid && res_ready;
    assign w_k_last   = (r_k == c_RW'(N - 1));
    assign w_u_last   = (r_u == c_RW'(N - 1));
    assign w_t_last   = (r_t == c_TW'(c_T_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_ready   = 1'b0;
        a_ready   = 1'b0;
        sa_en     = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_start_ok) begin
                    w_next = (keep_w && r_w_loaded) ? ST_LOAD_A : ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && w_k_last) begin
                    w_next = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                a_ready = 1'b1;
                if (a_valid && w_k_last) begin
                    w_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                sa_en = 1'b1;
                if (w_t_last) begin
                    w_next = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                res_valid = 1'b1;
                if (res_ready && w_u_last) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbuf     <= '0;
            r_abuf     <= '0;
            r_res      <= '0;
            r_k        <= '0;
            r_u        <= '0;
            r_t        <= '0;
            r_w_loaded <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_k <= '0;
            end
            if (w_w_fire) begin
                for (int i = 0; i < N; i++) begin
                    if (r_k == c_RW'(i)) begin
                        r_wbuf[row_lsb(i, N*DW) +: N*DW] <= w_data;
                    end
                end
                if (w_k_last) begin
                    r_k        <= '0;
                    r_w_loaded <= 1'b1;
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end
            if (w_a_fire) begin
                for (int i = 0; i < N; i++) begin
                    if (r_k == c_RW'(i)) begin
                        r_abuf[row_lsb(i, N*DW) +: N*DW] <= a_data;
                    end
                end
                if (w_k_last) begin
                    r_k <= '0;
                    r_t <= '0;
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end
            if (r_state == ST_STREAM) begin
                r_t <= w_t_last ? '0 : r_t + 1'b1;
                for (int j = 0; j < N; j++) begin
                    for (int r = 0; r < N; r++) begin
                        if (w_cap_en[j] && (w_cap_row[j*c_RW +: c_RW] == c_RW'(r))) begin
                            r_res[(r*N + j)*OW +: OW] <= sa_out[j*OW +: OW];
                        end
                    end
                end
                if (w_t_last) begin
                    r_u <= '0;
                end
            end
            if (w_r_fire) begin
                if (w_u_last) begin
                    r_u    <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_u <= r_u + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_res_row = '0;
        for (int r = 0; r < N; r++) begin
            if (r_u == c_RW'(r)) begin
                w_res_row = r_res[row_lsb(r, N*OW) +: N*OW];
            end
        end
    end

    assign sa_wgt   = r_wbuf;
    assign sa_in    = sa_en ? w_skew_in : '0;
    assign res_data = res_valid ? w_res_row : '0;
    assign done     = r_done;

`ifdef SEQ_PERF_EN
    logic [31:0] r_perf;

    // Counts busy cycles of the current job; stops once back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= '0;
        end else if (w_start_ok) begin
            r_perf <= '0;
        end else if (busy && (r_perf != '1)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sysa_sequencer.sv
// ============================================================================
// Module      : tb_sysa_sequencer
// Description : Self-checking bench for sysa_sequencer with a behavioural
//               array model and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sysa_sequencer;

    localparam int N   = 3;
    localparam int DW  = 8;
    localparam int OW  = 16;
    localparam int LAT = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              keep_w = 1'b0;
    logic              w_valid = 1'b0;
    logic              a_valid = 1'b0;
    logic              res_ready = 1'b0;
    logic [N*DW-1:0]   w_data = '0;
    logic [N*DW-1:0]   a_data = '0;
    logic              w_ready, a_ready, sa_en, res_valid, busy, done;
    logic [N*N*DW-1:0] sa_wgt;
    logic [N*DW-1:0]   sa_in;
    logic [N*OW-1:0]   sa_out;
    logic [N*OW-1:0]   res_data;
`ifdef SEQ_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tb_t = 0;
    int done_cnt = 0;
    bit wr_seen = 1'b0;
    int A[N][N];
    int W[N][N];
    logic [N*OW-1:0] exp_q[$];

    always #5 clk = ~clk;

    sysa_sequencer #(.N(N), .DW(DW), .OW(OW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .keep_w    (keep_w),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .sa_en     (sa_en),
        .sa_wgt    (sa_wgt),
        .sa_in     (sa_in),
        .sa_out    (sa_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done)
`ifdef SEQ_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    // Stream cycle index as seen by the array.
    always @(posedge clk) begin
        if (rst || !sa_en) tb_t <= 0;
        else               tb_t <= tb_t + 1;
    end

    // Array model: lane j presents row r = t-j-LAT; a marker value elsewhere.
    int             m_r;
    logic [OW-1:0]  m_acc;
    always_comb begin
        sa_out = '0;
        m_r    = 0;
        m_acc  = '0;
        for (int j = 0; j < N; j++) begin
            m_r   = tb_t - j - LAT;
            m_acc = OW'(32'hBAD0 + j);
            if (sa_en && m_r >= 0 && m_r < N) begin
                m_acc = '0;
                for (int k = 0; k < N; k++) begin
                    m_acc = m_acc + OW'(A[m_r][k] * int'(sa_wgt[(k*N + j)*DW +: DW]));
                end
            end
            sa_out[j*OW +: OW] = m_acc;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        int r;
        logic [DW-1:0] e;
        @(negedge clk);
        cyc++;
        if (w_ready) wr_seen = 1'b1;
        if (done) done_cnt++;
        if (sa_en) begin
            for (int k = 0; k < N; k++) begin
                r = tb_t - k;
                e = (r >= 0 && r < N) ? DW'(A[r][k]) : '0;
                chk($sformatf("sa_in t=%0d lane%0d", tb_t, k), sa_in[k*DW +: DW], e);
            end
        end else begin
            chk("sa_in idle", sa_in, '0);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " ctl"}, {w_ready, a_ready, sa_en, res_valid, busy, done}, '0);
        chk({tag, " sa_wgt"}, sa_wgt, '0);
        chk({tag, " sa_in"}, sa_in, '0);
        chk({tag, " res_data"}, res_data, '0);
    endtask

    task automatic push_expected();
        logic [N*OW-1:0] row;
        int acc;
        for (int r = 0; r < N; r++) begin
            row = '0;
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < N; k++) acc += A[r][k] * W[k][j];
                row[j*OW +: OW] = OW'(acc);
            end
            exp_q.push_back(row);
        end
    endtask

    task automatic start_job(input bit keep, output int c0);
        done_cnt = 0;
        wr_seen  = 1'b0;
        start    = 1'b1;
        keep_w   = keep;
        c0       = cyc;
        tick();
        start    = 1'b0;
        keep_w   = 1'b0;
        chk("busy after start", busy, 1'b1);
    endtask

    task automatic send_beat(input bit is_w, input logic [N*DW-1:0] d, input int gap);
        int n;
        n = 0;
        repeat (gap) tick();
        if (is_w) begin w_valid = 1'b1; w_data = d; end
        else      begin a_valid = 1'b1; a_data = d; end
        while (!(is_w ? w_ready : a_ready) && n < 40) begin
            tick();
            n++;
        end
        chk(is_w ? "w handshake" : "a handshake", n < 40, 1'b1);
        tick();
        w_valid = 1'b0;
        a_valid = 1'b0;
    endtask

    task automatic load_rows(input bit is_w, input bit gaps);
        logic [N*DW-1:0] row;
        for (int i = 0; i < N; i++) begin
            row = '0;
            for (int j = 0; j < N; j++) row[j*DW +: DW] = DW'(is_w ? W[i][j] : A[i][j]);
            send_beat(is_w, row, gaps ? int'($urandom_range(0, 2)) : 0);
        end
    endtask

    task automatic collect(input int stall_at, output int first_cyc);
        int n;
        logic [N*OW-1:0] e;
        first_cyc = 0;
        res_ready = 1'b1;
        for (int u = 0; u < N; u++) begin
            n = 0;
            while (!res_valid && n < 100) begin
                tick();
                n++;
            end
            chk("res_valid wait", n < 100, 1'b1);
            if (u == 0) first_cyc = cyc;
            e = (exp_q.size() > 0) ? exp_q[0] : '0;
            if (u == stall_at) begin
                res_ready = 1'b0;
                repeat (5) begin
                    tick();
                    chk("stall res_valid", res_valid, 1'b1);
                    chk("stall res_data", res_data, e);
                end
                res_ready = 1'b1;
            end
            chk($sformatf("res row %0d", u), res_data, e);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            tick();
        end
        res_ready = 1'b0;
        chk("done pulse", done, 1'b1);
        chk("busy low with done", busy, 1'b0);
        tick();
        chk("done single cycle", done, 1'b0);
        chk("done count", done_cnt, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, n;

        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Job 1: identity weights.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                W[i][j] = (i == j) ? 1 : 0;
                A[i][j] = i*N + j + 1;
            end
        push_expected();
        start_job(1'b0, c0);
        load_rows(1'b1, 1'b0);
        load_rows(1'b0, 1'b0);
        collect(-1, c1);
        chk("latency identity", c1 - c0, 4*N + LAT);

        // Job 2: all-2 weights, same activations.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) W[i][j] = 2;
        push_expected();
        start_job(1'b0, c0);
        load_rows(1'b1, 1'b0);
        load_rows(1'b0, 1'b0);
        collect(-1, c1);
        chk("latency all-2", c1 - c0, 4*N + LAT);

        // Job 3: reuse the loaded weights.
        push_expected();
        start_job(1'b1, c0);
        load_rows(1'b0, 1'b0);
        collect(-1, c1);
        chk("latency keep_w", c1 - c0, 3*N + LAT);
        chk("keep_w no w_ready", wr_seen, 1'b0);

        // Job 4: random data, input gaps, output stall mid-unload.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                W[i][j] = int'($urandom_range(0, 255));
                A[i][j] = int'($urandom_range(0, 255));
            end
        push_expected();
        start_job(1'b0, c0);
        load_rows(1'b1, 1'b1);
        load_rows(1'b0, 1'b1);
        collect(1, c1);

        // Job 5: abort by reset in the middle of streaming.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) W[i][j] = 2;
        start_job(1'b0, c0);
        load_rows(1'b1, 1'b0);
        load_rows(1'b0, 1'b0);
        n = 0;
        while (!(sa_en && tb_t == 2) && n < 50) begin
            tick();
            n++;
        end
        chk("reach stream t=2", n < 50, 1'b1);
        rst = 1'b1;
        tick();
        check_reset("mid-job reset");
        rst = 1'b0;
        tick();

        // Job 6: keep_w after reset must still load weights.
        push_expected();
        start_job(1'b1, c0);
        load_rows(1'b1, 1'b0);
        load_rows(1'b0, 1'b0);
        collect(-1, c1);
        chk("latency after reset", c1 - c0, 4*N + LAT);
        chk("w_ready after reset", wr_seen, 1'b1);
        chk("scoreboard empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sysa_sequencer.md
Name: sysa_sequencer

Overview:
Job-level controller for the 3x3 weight-stationary systolic array (sysa). It takes weight rows and activation rows over valid/ready streams and sequences the array through load, skewed stream and drain. It captures the diagonal output wavefront, de-skews it into a result buffer, and returns one result row per beat. It sits between the bus-side FIFO logic and the sysa instance, replacing ad-hoc counter FSMs in the top level.

Parameters:
N, 3, array dimension (rows = cols = lanes)
DW, 8, activation/weight element width
OW, 16, array output element width
LAT, 1, cycles from sa_in lane k entering to its contribution appearing on sa_out (array pipeline depth, >=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse: begin job (sampled in IDLE only)
keep_w  in  1  with start: reuse loaded weights, skip LOAD_W
w_valid  in  1  weight row valid
w_ready  out  1  weight row accepted when w_valid&&w_ready
w_data  in  N*DW  weight row k; element j at [j*DW+:DW]
a_valid  in  1  activation row valid
a_ready  out  1  activation handshake
a_data  in  N*DW  activation row r; element k at [k*DW+:DW]
sa_en  out  1  array enable
sa_wgt  out  N*N*DW  weight matrix, row k at [k*N*DW+:N*DW]
sa_in  out  N*DW  skewed input lanes
sa_out  in  N*OW  array output lanes
res_valid  out  1  result row valid
res_ready  in  1  result handshake
res_data  out  N*OW  result row r; element j at [j*OW+:OW]
busy  out  1  not IDLE
done  out  1  one-cycle pulse after last result beat accepted

Behaviour:
- Reset values: w_ready=0, a_ready=0, sa_en=0, sa_wgt=0, sa_in=0, res_valid=0, res_data=0, busy=0, done=0. w_loaded flag cleared; weight, activation and result buffers cleared.
- States: IDLE, LOAD_W, LOAD_A, STREAM, UNLOAD.
- IDLE: on start, go to LOAD_A if keep_w&&w_loaded, else LOAD_W. keep_w with w_loaded=0 behaves as keep_w=0. start outside IDLE is ignored.
- LOAD_W: w_ready=1. Accept N rows in order k=0..N-1 into the weight buffer. After beat N-1, set w_loaded=1 and go to LOAD_A. sa_wgt continuously reflects the weight buffer.
- LOAD_A: a_ready=1. Accept N rows r=0..N-1. After beat N-1, clear t=0 and go to STREAM. Valid without ready is never accepted, and nothing is dropped.
- STREAM: sa_en=1. Counter t runs 0..2N-2+LAT, one step per cycle, with no stalls. Lane k of sa_in = a[t-k][k] when 0<=t-k<=N-1, else 0.
- Capture: output lane j holds result row r at t = r+j+LAT. At that cycle, store sa_out lane j into result[r][j].
- At t=2N-2+LAT, after the final capture, go to UNLOAD with row index u=0.
- Results are unsigned sums. Wrap modulo 2^OW is the array's concern; the sequencer does no saturation.
- UNLOAD: res_valid=1, res_data=result[u]. u advances on res_valid&&res_ready. res_data is held stable while stalled. After beat N-1, pulse done for 1 cycle and return to IDLE.
- Latency with no backpressure, from start to first res_valid: N (if LOAD_W) + N + 2N-1+LAT + 1 cycles.
- rst mid-job: abort immediately, reset values as listed, w_loaded=0.
- Simultaneous start and done: done is issued in UNLOAD→IDLE; start is sampled from the next cycle only.

Optional Feature:
SEQ_PERF_EN
- Defined: adds output perf_cycles (32 bits), reset 0. Cleared on an accepted start and counts every cycle while busy. Freezes at done and saturates at all-ones.
- Undefined: port and counter are absent.

Decomposition:
- Shared package sysa_pkg:
  - state encoding localparams (IDLE..UNLOAD)
  - N/DW/OW defaults
  - row-slice helper macros
- One natural sub-module: sysa_skew, which produces sa_in from the activation buffer and t, and computes per-lane capture enables (r,j) from t. It is purely combinational with LAT as a parameter.

Test Plan:
- Identity weights, a rows [1,2,3],[4,5,6],[7,8,9] (bench sysa model with LAT=1) -> results [1,2,3],[4,5,6],[7,8,9]; done pulses once; busy falls with done.
- All-2 weights, same a -> results [12,12,12],[30,30,30],[48,48,48].
- Second job with keep_w=1 after the all-2 job -> no w_ready asserted, same results. Job is N cycles shorter.
- Random w_valid/a_valid gaps and res_ready held low 5 cycles mid-UNLOAD -> no lost or duplicated rows; res_data stable while stalled.
- rst asserted during STREAM at t=2, then new job with keep_w=1 -> goes through LOAD_W (w_loaded cleared); all outputs at reset values the cycle after rst.
- Check sa_in skew per cycle. Lane 2 first nonzero at t=2 (value 3 in the identity job), and all lanes are 0 for t>2N-2.
